// File: rtl/fb_port_arbiter.sv
// Single-port frame buffer arbiter: rasterizer writes vs. bootloader reads (round-robin
// on conflict), plus a fill-colour clear engine compiled in when FB_ARB_CLEAR_EN is defined.
module fb_port_arbiter #(
  parameter int unsigned FB_DEPTH = 307200,
  parameter int unsigned ADDR_W   = 21,
  parameter int unsigned PIX_W    = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [PIX_W-1:0]  rd_data,
  input  logic              clear_start,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_wdata,
  input  logic [PIX_W-1:0]  fb_rdata
);

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic {RR_WRITE, RR_READ} rr_t;

  state_t state, state_next;
  rr_t    rr_last, rr_next;

  logic              clear_go;
  logic              clr_last;
  logic [ADDR_W-1:0] clr_addr;
  logic [PIX_W-1:0]  clr_color;

  assign rd_data = fb_rdata;

`ifdef FB_ARB_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  logic done_q;

  assign clear_go = clear_start;
  assign clr_last = (state == CLEAR) && (clr_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr  <= '0;
      clr_color <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= clr_last;
      if (state == CLEAR) begin
        clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
      end else if (clear_start) begin
        clr_color <= clear_color;
      end
    end
  end

  // Reset silences the clear status in the same cycle so an abort never shows busy/done.
  assign clear_busy = !reset && (state == CLEAR);
  assign clear_done = !reset && done_q;
`else
  logic unused_clear;

  assign unused_clear = ^{clear_start, clear_color, 32'(FB_DEPTH)};
  assign clear_go     = 1'b0;
  assign clr_last     = 1'b0;
  assign clr_addr     = '0;
  assign clr_color    = '0;
  assign clear_busy   = 1'b0;
  assign clear_done   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_last  <= RR_READ;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_next;
      rr_last  <= rr_next;
      rd_valid <= rd_gnt;
    end
  end

  always_comb begin
    state_next = state;
    rr_next    = rr_last;
    wr_gnt     = 1'b0;
    rd_gnt     = 1'b0;
    fb_we      = 1'b0;
    fb_addr    = '0;
    fb_wdata   = '0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (wr_req && (!rd_req || rr_last == RR_READ)) begin
            wr_gnt = 1'b1;
          end else if (rd_req) begin
            rd_gnt = 1'b1;
          end
          if (wr_req && rd_req) begin
            rr_next = wr_gnt ? RR_WRITE : RR_READ;
          end
          if (wr_gnt) begin
            fb_we    = 1'b1;
            fb_addr  = wr_addr;
            fb_wdata = wr_data;
          end else if (rd_gnt) begin
            fb_addr = rd_addr;
          end
          if (clear_go) begin
            state_next = CLEAR;
          end
        end
        CLEAR: begin
          fb_we    = 1'b1;
          fb_addr  = clr_addr;
          fb_wdata = clr_color;
          if (clr_last) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: vector table, clear corner sequences
// (when FB_ARB_CLEAR_EN is defined) and randomized traffic against a reference model.
module tb_fb_port_arbiter;

  localparam int unsigned FB_DEPTH = 16;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned PIX_W    = 24;
`ifdef FB_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [PIX_W-1:0]  rd_data;
  logic              clear_start;
  logic [PIX_W-1:0]  clear_color;
  logic              clear_busy;
  logic              clear_done;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [PIX_W-1:0]  fb_wdata;
  logic [PIX_W-1:0]  fb_rdata = '0;

  fb_port_arbiter #(.FB_DEPTH(FB_DEPTH), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata)
  );

  always #5 clk = ~clk;

  // Frame buffer: registered read, read-before-write.
  logic [PIX_W-1:0] mem [0:31] = '{default: '0};
  always @(posedge clk) begin
    if (fb_we) mem[fb_addr] <= fb_wdata;
    fb_rdata <= mem[fb_addr];
  end

  typedef struct {
    logic             rst;
    logic             wr;
    logic [4:0]       wa;
    logic [23:0]      wd;
    logic             rd;
    logic [4:0]       ra;
    logic             cs;
    logic [23:0]      cc;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        x_wg;
    logic        x_rg;
    logic        x_rv;
    logic        x_we;
    logic [4:0]  x_addr;
    logic [23:0] x_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  int unsigned m_left = 0;
  logic        m_done = 1'b0;
  logic        m_pref_w = 1'b1;
  logic        m_rdv = 1'b0;
  logic [23:0] m_rdd = '0;
  logic [23:0] m_color = '0;
  logic [23:0] m_mem [0:31] = '{default: '0};

  logic        e_wr, e_rd, e_we, e_busy, e_done;
  logic [4:0]  e_addr;
  logic [23:0] e_wdata;

  function automatic stim_t mk(input logic rst, input logic wr, input logic [4:0] wa,
                               input logic [23:0] wd, input logic rd, input logic [4:0] ra,
                               input logic cs, input logic [23:0] cc);
    stim_t s;
    s.rst = rst; s.wr = wr; s.wa = wa; s.wd = wd;
    s.rd = rd; s.ra = ra; s.cs = cs; s.cc = cc;
    return s;
  endfunction

  function automatic vec_t mkv(input stim_t s, input logic wg, input logic rg, input logic rv,
                               input logic we, input logic [4:0] addr, input logic [23:0] rdata);
    vec_t v;
    v.s = s; v.x_wg = wg; v.x_rg = rg; v.x_rv = rv;
    v.x_we = we; v.x_addr = addr; v.x_rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic apply(input stim_t s);
    reset = s.rst; wr_req = s.wr; wr_addr = s.wa; wr_data = s.wd;
    rd_req = s.rd; rd_addr = s.ra; clear_start = s.cs; clear_color = s.cc;
    #3;
    e_wr = 1'b0; e_rd = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_busy = 1'b0; e_done = 1'b0;
    if (!s.rst) begin
      e_busy = (m_left > 0);
      e_done = m_done;
      if (e_busy) begin
        e_we = 1'b1; e_addr = 5'(FB_DEPTH - m_left); e_wdata = m_color;
      end else begin
        if (s.wr && s.rd) begin
          e_wr = m_pref_w; e_rd = !m_pref_w;
        end else begin
          e_wr = s.wr; e_rd = s.rd;
        end
        if (e_wr) begin
          e_we = 1'b1; e_addr = s.wa; e_wdata = s.wd;
        end else if (e_rd) begin
          e_addr = s.ra;
        end
      end
    end
    chk("wr_gnt", 32'(wr_gnt), 32'(e_wr));
    chk("rd_gnt", 32'(rd_gnt), 32'(e_rd));
    chk("fb_we", 32'(fb_we), 32'(e_we));
    chk("fb_addr", 32'(fb_addr), 32'(e_addr));
    if (!e_rd) chk("fb_wdata", 32'(fb_wdata), 32'(e_wdata));
    chk("clear_busy", 32'(clear_busy), 32'(e_busy));
    chk("clear_done", 32'(clear_done), 32'(e_done));
    chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
    if (m_rdv) chk("rd_data", 32'(rd_data), 32'(m_rdd));
  endtask

  task automatic advance(input stim_t s);
    @(posedge clk);
    #1;
    cyc++;
    if (s.rst) begin
      m_left = 0; m_done = 1'b0; m_pref_w = 1'b1; m_rdv = 1'b0;
    end else begin
      m_rdv = e_rd;
      if (e_rd) m_rdd = m_mem[s.ra];
      if (e_we) m_mem[e_addr] = e_wdata;
      if (!e_busy && s.wr && s.rd) m_pref_w = !m_pref_w;
      m_done = (m_left == 1);
      if (m_left > 0) m_left--;
      else if (CLEAR_EN && s.cs) begin
        m_left = FB_DEPTH; m_color = s.cc;
      end
    end
  endtask

  task automatic step(input stim_t s);
    apply(s);
    advance(s);
  endtask

  task automatic run_until_done(input string name);
    stim_t idle;
    logic  seen;
    idle = mk(1'b0, 1'b0, 5'd0, 24'h0, 1'b0, 5'd0, 1'b0, 24'h0);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      apply(idle);
      if (clear_done) seen = 1'b1;
      advance(idle);
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vec [0:10];
    stim_t idle, rst, both, s;
    int    busy_n, done_n, wgnt_busy;
    logic  seen;

    idle = mk(1'b0, 1'b0, 5'd0, 24'h0, 1'b0, 5'd0, 1'b0, 24'h0);
    rst  = mk(1'b1, 1'b0, 5'd0, 24'h0, 1'b0, 5'd0, 1'b0, 24'h0);
    both = mk(1'b0, 1'b1, 5'd3, 24'h111111, 1'b1, 5'd0, 1'b0, 24'h0);

    vec[0]  = mkv(rst, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 24'h0);
    vec[1]  = mkv(idle, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 24'h0);
    vec[2]  = mkv(mk(1'b0, 1'b1, 5'd0, 24'h34ABCD, 1'b0, 5'd0, 1'b0, 24'h0),
                  1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 24'h0);
    vec[3]  = mkv(mk(1'b0, 1'b0, 5'd0, 24'h0, 1'b1, 5'd0, 1'b0, 24'h0),
                  1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 24'h0);
    vec[4]  = mkv(idle, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 24'h34ABCD);
    vec[5]  = mkv(rst, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 24'h0);
    vec[6]  = mkv(both, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 24'h0);
    vec[7]  = mkv(both, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 24'h0);
    vec[8]  = mkv(both, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 24'h34ABCD);
    vec[9]  = mkv(both, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 24'h0);
    vec[10] = mkv(idle, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 24'h34ABCD);

    reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; clear_start = 1'b0; clear_color = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      apply(vec[i].s);
      chk("tbl_wr_gnt", 32'(wr_gnt), 32'(vec[i].x_wg));
      chk("tbl_rd_gnt", 32'(rd_gnt), 32'(vec[i].x_rg));
      chk("tbl_rd_valid", 32'(rd_valid), 32'(vec[i].x_rv));
      chk("tbl_fb_we", 32'(fb_we), 32'(vec[i].x_we));
      chk("tbl_fb_addr", 32'(fb_addr), 32'(vec[i].x_addr));
      if (vec[i].x_rv) chk("tbl_rd_data", 32'(rd_data), 32'(vec[i].x_rdata));
      advance(vec[i].s);
    end

`ifdef FB_ARB_CLEAR_EN
    // Full sweep with green, then read every address back.
    step(mk(1'b0, 1'b0, 5'd0, 24'h0, 1'b0, 5'd0, 1'b1, 24'h00FF00));
    busy_n = 0; done_n = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      apply(idle);
      if (k == 0) chk("clr_busy_rise", 32'(clear_busy), 32'd1);
      if (clear_busy) begin
        chk("clr_sweep_addr", 32'(fb_addr), 32'(busy_n));
        chk("clr_sweep_we", 32'(fb_we), 32'd1);
        busy_n++;
      end
      if (clear_done) begin
        done_n++; seen = 1'b1;
        chk("clr_done_busy", 32'(clear_busy), 32'd0);
      end
      advance(idle);
    end
    for (int k = 0; k < 3; k++) begin
      apply(idle);
      if (clear_done) done_n++;
      advance(idle);
    end
    chk("clr_busy_cycles", 32'(busy_n), 32'd16);
    chk("clr_done_pulses", 32'(done_n), 32'd1);

    for (int a = 0; a <= 16; a++) begin
      if (a < 16) s = mk(1'b0, 1'b0, 5'd0, 24'h0, 1'b1, 5'(a), 1'b0, 24'h0);
      else s = idle;
      apply(s);
      if (a > 0) begin
        chk("readback_valid", 32'(rd_valid), 32'd1);
        chk("readback_data", 32'(rd_data), 32'h00FF00);
      end
      advance(s);
    end

    // Write held across a sweep, with a second clear_start at sweep cycle 5.
    step(mk(1'b0, 1'b0, 5'd0, 24'h0, 1'b0, 5'd0, 1'b1, 24'h0000FF));
    busy_n = 0; wgnt_busy = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      s = mk(1'b0, 1'b1, 5'd9, 24'h000ABC, 1'b0, 5'd0, (k == 5), 24'hDEAD00);
      apply(s);
      if (clear_busy) begin
        busy_n++;
        if (wr_gnt) wgnt_busy++;
      end
      if (clear_done) begin
        seen = 1'b1;
        chk("held_wr_gnt_at_done", 32'(wr_gnt), 32'd1);
      end
      advance(s);
    end
    chk("held_busy_cycles", 32'(busy_n), 32'd16);
    chk("held_wr_gnt_in_busy", 32'(wgnt_busy), 32'd0);
    apply(idle);
    chk("no_restart_busy", 32'(clear_busy), 32'd0);
    advance(idle);

    // Read issued in the same cycle as clear_start returns during the first CLEAR cycle.
    s = mk(1'b0, 1'b0, 5'd0, 24'h0, 1'b1, 5'd9, 1'b1, 24'h0F0F0F);
    apply(s);
    chk("sim_rd_gnt", 32'(rd_gnt), 32'd1);
    advance(s);
    apply(idle);
    chk("sim_busy", 32'(clear_busy), 32'd1);
    chk("sim_rd_valid", 32'(rd_valid), 32'd1);
    chk("sim_rd_data", 32'(rd_data), 32'h000ABC);
    advance(idle);
    run_until_done("sim_done_seen");

    // Reset at sweep cycle 7 aborts; a fresh clear starts from address 0.
    step(mk(1'b0, 1'b0, 5'd0, 24'h0, 1'b0, 5'd0, 1'b1, 24'h123456));
    for (int k = 0; k < 7; k++) step(idle);
    apply(rst);
    chk("abort_busy", 32'(clear_busy), 32'd0);
    chk("abort_we", 32'(fb_we), 32'd0);
    advance(rst);
    done_n = 0;
    for (int k = 0; k < 20; k++) begin
      apply(idle);
      if (clear_done) done_n++;
      chk("abort_idle_busy", 32'(clear_busy), 32'd0);
      advance(idle);
    end
    chk("abort_no_done", 32'(done_n), 32'd0);
    step(mk(1'b0, 1'b0, 5'd0, 24'h0, 1'b0, 5'd0, 1'b1, 24'h654321));
    apply(idle);
    chk("restart_busy", 32'(clear_busy), 32'd1);
    chk("restart_addr", 32'(fb_addr), 32'd0);
    chk("restart_data", 32'(fb_wdata), 32'h654321);
    advance(idle);
    run_until_done("restart_done_seen");
`else
    // Clear engine absent: clear_start is ignored and writes keep flowing.
    step(mk(1'b0, 1'b1, 5'd2, 24'h000005, 1'b0, 5'd0, 1'b1, 24'hABCDEF));
    for (int k = 0; k < 20; k++) begin
      s = mk(1'b0, 1'b1, 5'd4, 24'h000007, 1'b0, 5'd0, (k == 3), 24'h00FF00);
      apply(s);
      chk("off_busy", 32'(clear_busy), 32'd0);
      chk("off_done", 32'(clear_done), 32'd0);
      chk("off_wr_gnt", 32'(wr_gnt), 32'd1);
      advance(s);
    end
`endif

    for (int n = 0; n < 3000; n++) begin
      s.rst = ($urandom_range(0, 399) == 0);
      s.wr  = ($urandom_range(0, 99) < 60);
      s.wa  = 5'($urandom_range(0, 15));
      s.wd  = 24'($urandom);
      s.rd  = ($urandom_range(0, 99) < 60);
      s.ra  = 5'($urandom_range(0, 15));
      s.cs  = ($urandom_range(0, 59) == 0);
      s.cc  = 24'($urandom);
      step(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Arbiter and sequencer for the single-port frame buffer. It shares the frame buffer between three users: the rasterizer's pixel writes, the bootloader's transmit-path pixel reads, and an internal clear engine that fills the buffer with a color before each frame. It sits between those users and the `frame_buffer` instance. It owns `write_enable`, `addr` and `data`, replacing the external `read_fb ? ... : ...` address mux.

## Interface

Parameters:
- `FB_DEPTH`, default 307200: number of pixels; the clear engine sweeps addresses 0..FB_DEPTH-1.
- `ADDR_W`, default 21: frame buffer address width.
- `PIX_W`, default 24: RGB pixel width.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `wr_req` input 1: rasterizer requests a pixel write this cycle.
- `wr_addr` input ADDR_W: write address.
- `wr_data` input PIX_W: write pixel.
- `wr_gnt` output 1: write performed this cycle (combinational).
- `rd_req` input 1: bootloader requests a pixel read this cycle.
- `rd_addr` input ADDR_W: read address.
- `rd_gnt` output 1: read issued this cycle (combinational).
- `rd_valid` output 1: registered; `rd_data` holds the granted read's result.
- `rd_data` output PIX_W: pass-through of `fb_rdata`.
- `clear_start` input 1: pulse that starts a clear.
- `clear_color` input PIX_W: fill color, sampled on an accepted `clear_start`.
- `clear_busy` output 1: clear sweep in progress.
- `clear_done` output 1: one-cycle pulse after the last clear write.
- `fb_we` output 1: frame buffer write enable.
- `fb_addr` output ADDR_W: frame buffer address.
- `fb_wdata` output PIX_W: frame buffer write data.
- `fb_rdata` input PIX_W: frame buffer read data, one-cycle registered read latency.

## Operation

State machine:
- States are IDLE and CLEAR.
- Reset enters IDLE with `clr_addr`=0, `rr_last`=READ (so the first conflict goes to write) and `rd_valid`=0.

IDLE arbitration:
- Only `wr_req` asserted: grant write.
- Only `rd_req` asserted: grant read.
- Both asserted: grant the one not granted at the previous conflict (round-robin); `rr_last` updates only on conflicts.
- Write grant: `fb_we`=1, `fb_addr`=`wr_addr`, `fb_wdata`=`wr_data`.
- Read grant: `fb_we`=0, `fb_addr`=`rd_addr`.
- No grant: `fb_we`=0, `fb_addr`=0, `fb_wdata`=0.
- Requesters hold `req` and its address/data until they see `gnt`.

Starting a clear:
- `clear_start` in IDLE latches `clear_color` and moves to CLEAR on the next cycle.
- Requests in that same cycle are still arbitrated and served normally.

CLEAR:
- `fb_we`=1, `fb_addr`=`clr_addr`, `fb_wdata`=latched color.
- `clr_addr` increments each cycle; `wr_gnt`=`rd_gnt`=0 throughout.
- The cycle that writes FB_DEPTH-1 is the last CLEAR cycle: `clr_addr` returns to 0, `clear_done` pulses on the following cycle, and the state returns to IDLE on that cycle.
- Requests resume being served in the `clear_done` cycle.
- `clear_start` during CLEAR is ignored; the color is not re-latched.

Read return:
- `rd_valid` is `rd_gnt` delayed by one cycle.
- A read granted in the last IDLE cycle before CLEAR still returns `rd_valid` in the first CLEAR cycle.

Arithmetic:
- `clr_addr` is ADDR_W bits, compared against FB_DEPTH-1; no wrap beyond FB_DEPTH.

Reset mid-clear:
- Aborts immediately: IDLE, `clr_addr`=0, no `clear_done`.

## Timing

Reset values (in the cycle after reset): `wr_gnt`, `rd_gnt`, `rd_valid`, `clear_busy`, `clear_done`, `fb_we` all 0; `fb_addr`=0; `fb_wdata`=0.

While `reset` is high, all grants are forced to 0.

Latencies:
- Write: same cycle as the grant.
- Read: `rd_valid` and data one cycle after `rd_gnt`.
- Clear: `clear_busy` rises one cycle after `clear_start` and stays high exactly FB_DEPTH cycles; `clear_done` follows in the next cycle, with `clear_busy`=0.

Fairness: under continuous two-way contention, write and read alternate every cycle, so there is no starvation.

## Configuration

`FB_ARB_CLEAR_EN`:
- Defined: the clear engine and CLEAR state are compiled in, as described above.
- Undefined: `clear_start` and `clear_color` are ignored, `clear_busy` and `clear_done` are tied 0, and the block is a pure two-way round-robin arbiter in IDLE permanently.

## Test plan

- Write only: `wr_req`=1, `wr_addr`=0, `wr_data`=24'h34ABCD → `wr_gnt`=1 and `fb_we`=1 the same cycle. A following `rd_req` at addr 0 → `rd_valid` the next cycle with `rd_data`=24'h34ABCD.
- Contention: `wr_req` and `rd_req` both held for 4 cycles after reset → grants are W,R,W,R; `rd_valid` is high in the cycle after each R.
- Clear (FB_DEPTH=16 in the bench, `clear_color`=24'h00FF00):
  - `clear_busy` is high for 16 cycles.
  - `fb_addr` steps 0..15 with `fb_we`=1.
  - `clear_done` pulses once.
  - A read-back of all 16 addresses returns 24'h00FF00.
- Requests during clear: `wr_req` held across the sweep → `wr_gnt`=0 for all 16 cycles, then 1 in the `clear_done` cycle. A second `clear_start` at sweep cycle 5 → no restart, total of 16 busy cycles.
- Simultaneous start: `clear_start` with `rd_req` in IDLE → `rd_gnt`=1 that cycle, and `rd_valid` with correct data in the first CLEAR cycle.
- Reset mid-clear: `reset` at sweep cycle 7 → `clear_busy`=0, no `clear_done`. A new clear then restarts at `fb_addr`=0.
